branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Consumer end of the ALU flag interface. Takes ZF/SF/CF/OF produced by an ALU subtract (A - B, OP=4'b1000) for a conditional branch, together with funct3, PC, immediate and the fetch-stage prediction. Produces a registered taken/target/mispredict result one cycle later. Owns a small branch history table (BHT) of 2-bit saturating counters that fetch reads for prediction.

Parameters:
XLEN, 32, data/address width
BHT_IDX_W, 6, log2 of BHT entries (64 entries), indexed by pc[BHT_IDX_W+1:2]

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  branch present this cycle
in_kill  input  1  squash the current input (pipeline flush from an older instruction)
in_funct3  input  3  branch type
in_zf  input  1  ALU zero flag of A-B
in_sf  input  1  ALU sign flag (result bit 31)
in_cf  input  1  ALU carry flag; 1 = borrow, i.e. A < B unsigned
in_of  input  1  ALU signed-overflow flag
in_pc  input  XLEN  branch instruction PC
in_imm  input  XLEN  sign-extended B-type immediate
in_pred_taken  input  1  prediction used by fetch
pred_pc  input  XLEN  fetch lookup PC
pred_taken  output  1  combinational: MSB of BHT[pred_pc index]
out_valid  output  1  registered result valid
out_taken  output  1  resolved direction
out_target  output  XLEN  in_pc + in_imm
out_redirect_pc  output  XLEN  taken ? target : pc + 4
out_mispredict  output  1  redirect required
out_illegal  output  1  funct3 010/011
out_misalign  output  1  taken and target[1:0] != 0

Behaviour:
- Accept = in_valid & ~in_kill & ~rst. All out_* are registered. Latency 1: results appear the cycle after accept.
- Cycles with no accept: out_valid=0. Other out_* are don't-care but hold their previous values.
- Reset: out_valid, out_taken, out_mispredict, out_illegal and out_misalign are 0; out_target and out_redirect_pc are 0. All BHT entries are set to 2'b01 (weakly not-taken), written in that same single reset cycle.
- Condition by funct3:
  - 000 BEQ: ZF
  - 001 BNE: ~ZF
  - 100 BLT: SF^OF
  - 101 BGE: ~(SF^OF)
  - 110 BLTU: CF
  - 111 BGEU: ~CF
- Illegal funct3 (010, 011): out_illegal=1, out_taken=0, out_mispredict=0, no BHT update.
- Address arithmetic is modulo 2^XLEN. out_target = pc + imm; pc + 4 wraps silently (0xFFFFFFFC + 4 = 0).
- out_mispredict = (taken != in_pred_taken) for legal branches.
- out_misalign is flagged only when taken. When out_misalign=1, out_mispredict is forced 0; the trap path handles the redirect. The BHT still updates.
- BHT update on accept of a legal branch, at the same clock edge as result capture:
  - taken: counter +1, saturating at 3
  - not taken: counter -1, saturating at 0
- Lookup and update of the same index in the same cycle: pred_taken returns the pre-update value (no bypass).
- in_kill together with in_valid: no capture, no BHT change, out_valid=0 next cycle.
- rst asserted mid-stream overrides any accept in that cycle.

Optional Feature:
BRU_STATS_EN:
- Defined: adds three outputs, stat_branches, stat_taken and stat_mispredicts, each 32 bits.
- Counters increment on accept of legal branches only (stat_mispredicts uses the same condition as out_mispredict). They wrap modulo 2^32 and clear on rst.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then read pred_pc=0x00 and 0xFC → pred_taken=0 for both; out_valid=0.
- BEQ: ZF=1, pc=0x100, imm=0x20, pred=0 → next cycle out_valid=1, taken=1, target=0x120, redirect=0x120, mispredict=1.
- BLT with SF=1, OF=1 (no branch) and pred=0 → taken=0, mispredict=0, redirect=pc+4. BLTU with CF=1 → taken=1.
- Four taken BNEs at pc=0x40 → counter goes 01→10→11→11; pred_taken(0x40)=1 from the cycle after the first update. A same-cycle lookup returns the old value.
- funct3=010 → out_illegal=1, taken=0, BHT unchanged. in_valid=1 with in_kill=1 → out_valid=0, BHT unchanged.
- pc=0xFFFFFFFC, not taken → redirect=0x0. Taken with imm=0x2 → out_misalign=1, mispredict=0. rst mid-sequence → out_valid=0 next cycle and all counters back to 01.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Branch resolve interface: groups the branch-resolution request, the
// fetch-side BHT lookup and the registered result bundle.
//   master : producer side (issue/fetch), drives in_* and pred_pc
//   slave  : branch_resolve_unit, drives pred_taken and out_*
// Optional macro BRU_STATS_EN adds stat_branches/stat_taken/stat_mispredicts.
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_kill;
  logic [2:0]      in_funct3;
  logic            in_zf;
  logic            in_sf;
  logic            in_cf;
  logic            in_of;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            out_valid;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_mispredict;
  logic            out_illegal;
  logic            out_misalign;
`ifdef BRU_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_taken;
  logic [31:0]     stat_mispredicts;
`endif

  modport master (
    output in_valid, in_kill, in_funct3, in_zf, in_sf, in_cf, in_of,
           in_pc, in_imm, in_pred_taken, pred_pc,
    input  pred_taken, out_valid, out_taken, out_target, out_redirect_pc,
           out_mispredict, out_illegal, out_misalign
`ifdef BRU_STATS_EN
   ,input  stat_branches, stat_taken, stat_mispredicts
`endif
  );

  modport slave (
    input  in_valid, in_kill, in_funct3, in_zf, in_sf, in_cf, in_of,
           in_pc, in_imm, in_pred_taken, pred_pc,
    output pred_taken, out_valid, out_taken, out_target, out_redirect_pc,
           out_mispredict, out_illegal, out_misalign
`ifdef BRU_STATS_EN
   ,output stat_branches, stat_taken, stat_mispredicts
`endif
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates conditional-branch direction from ALU
// subtract flags, computes target/redirect, flags mispredict/illegal/
// misalign one cycle after accept, and owns a BHT of 2-bit counters.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : branch_resolve_if.slave (request, BHT lookup, registered result)
// Optional macro BRU_STATS_EN enables 32-bit branch/taken/mispredict counters.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  branch_resolve_if.slave   bus
);
  localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_W;

  logic [1:0]           r_bht [BHT_ENTRIES];

  logic                 w_accept;
  logic                 w_illegal;
  logic                 w_cond;
  logic                 w_taken;
  logic                 w_misalign;
  logic                 w_mispredict;
  logic [XLEN-1:0]      w_target;
  logic [XLEN-1:0]      w_seq_pc;
  logic [XLEN-1:0]      w_redirect;
  logic [BHT_IDX_W-1:0] w_upd_idx;
  logic [BHT_IDX_W-1:0] w_pred_idx;
  logic [1:0]           w_bht_cur;
  logic [1:0]           w_bht_next;
  logic                 w_unused_pred_bits;

  assign w_accept   = bus.in_valid & ~bus.in_kill & ~rst;
  assign w_illegal  = (bus.in_funct3[2:1] == 2'b01);
  assign w_upd_idx  = bus.in_pc[BHT_IDX_W+1:2];
  assign w_pred_idx = bus.pred_pc[BHT_IDX_W+1:2];
  assign w_unused_pred_bits = ^{bus.pred_pc[XLEN-1:BHT_IDX_W+2], bus.pred_pc[1:0]};

  // Lookup reads the stored counter; an update in the same cycle lands at
  // the edge, so fetch sees the pre-update value.
  assign bus.pred_taken = r_bht[w_pred_idx][1];

  always_comb begin
    w_cond = 1'b0;
    case (bus.in_funct3)
      3'b000:  w_cond = bus.in_zf;
      3'b001:  w_cond = ~bus.in_zf;
      3'b100:  w_cond = bus.in_sf ^ bus.in_of;
      3'b101:  w_cond = ~(bus.in_sf ^ bus.in_of);
      3'b110:  w_cond = bus.in_cf;
      3'b111:  w_cond = ~bus.in_cf;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken      = w_cond & ~w_illegal;
  assign w_target     = bus.in_pc + bus.in_imm;
  assign w_seq_pc     = bus.in_pc + XLEN'(4);
  assign w_redirect   = w_taken ? w_target : w_seq_pc;
  assign w_misalign   = w_taken & (w_target[1:0] != 2'b00);
  // A misaligned taken target goes to the trap path, so no fetch redirect.
  assign w_mispredict = ~w_illegal & ~w_misalign & (w_taken != bus.in_pred_taken);

  always_comb begin
    w_bht_cur  = r_bht[w_upd_idx];
    w_bht_next = w_bht_cur;
    if (w_taken) begin
      if (w_bht_cur != 2'b11) w_bht_next = w_bht_cur + 2'b01;
    end else begin
      if (w_bht_cur != 2'b00) w_bht_next = w_bht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid       <= 1'b0;
      bus.out_taken       <= 1'b0;
      bus.out_target      <= '0;
      bus.out_redirect_pc <= '0;
      bus.out_mispredict  <= 1'b0;
      bus.out_illegal     <= 1'b0;
      bus.out_misalign    <= 1'b0;
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
    end else begin
      bus.out_valid <= w_accept;
      if (w_accept) begin
        bus.out_taken       <= w_taken;
        bus.out_target      <= w_target;
        bus.out_redirect_pc <= w_redirect;
        bus.out_mispredict  <= w_mispredict;
        bus.out_illegal     <= w_illegal;
        bus.out_misalign    <= w_misalign;
        if (!w_illegal) r_bht[w_upd_idx] <= w_bht_next;
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_taken;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_branches    <= '0;
      r_stat_taken       <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_accept && !w_illegal) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (w_taken)      r_stat_taken       <= r_stat_taken + 32'd1;
      if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign bus.stat_branches    = r_stat_branches;
  assign bus.stat_taken       = r_stat_taken;
  assign bus.stat_mispredicts = r_stat_mispredicts;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(32)) bf ();

  branch_resolve_unit #(.XLEN(32), .BHT_IDX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic k, input logic [2:0] f3,
                       input logic zf, input logic sf, input logic cf, input logic of_,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pr);
    bf.in_valid = v; bf.in_kill = k; bf.in_funct3 = f3;
    bf.in_zf = zf; bf.in_sf = sf; bf.in_cf = cf; bf.in_of = of_;
    bf.in_pc = pc; bf.in_imm = imm; bf.in_pred_taken = pr;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic t,
                         input logic [31:0] tgt, input logic [31:0] rd,
                         input logic mp, input logic il, input logic ma);
    chk({tag, ".valid"}, 32'(bf.out_valid), 32'(v));
    chk({tag, ".taken"}, 32'(bf.out_taken), 32'(t));
    chk({tag, ".target"}, bf.out_target, tgt);
    chk({tag, ".redirect"}, bf.out_redirect_pc, rd);
    chk({tag, ".mispred"}, 32'(bf.out_mispredict), 32'(mp));
    chk({tag, ".illegal"}, 32'(bf.out_illegal), 32'(il));
    chk({tag, ".misalign"}, 32'(bf.out_misalign), 32'(ma));
  endtask

  task automatic chk_pred(input string tag, input logic [31:0] pc, input logic exp);
    bf.pred_pc = pc;
    #1;
    chk(tag, 32'(bf.pred_taken), 32'(exp));
  endtask

  initial begin
    drive(0, 0, 3'b000, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    bf.pred_pc = 32'h0;

    // Reset
    step(); step();
    chk("rst.valid", 32'(bf.out_valid), 32'd0);
    chk("rst.target", bf.out_target, 32'h0);
    chk("rst.redirect", bf.out_redirect_pc, 32'h0);
    chk_pred("rst.pred00", 32'h00, 1'b0);
    chk_pred("rst.predFC", 32'hFC, 1'b0);
    rst = 1'b0;

    // BEQ taken, predicted not-taken (BHT idx 0: 01->10)
    drive(1, 0, 3'b000, 1, 0, 0, 0, 32'h100, 32'h20, 0);
    step();
    chk_out("beq", 1, 1, 32'h120, 32'h120, 1, 0, 0);
    chk_pred("beq.bht0", 32'h0, 1'b1);

    // BLT SF=1 OF=1 -> not taken (idx 1: 01->00)
    drive(1, 0, 3'b100, 0, 1, 0, 1, 32'h204, 32'h40, 0);
    step();
    chk_out("blt", 1, 0, 32'h244, 32'h208, 0, 0, 0);

    // BLTU CF=1 -> taken, backwards imm, predicted taken
    drive(1, 0, 3'b110, 0, 0, 1, 0, 32'h308, 32'hFFFF_FFF0, 1);
    step();
    chk_out("bltu", 1, 1, 32'h2F8, 32'h2F8, 0, 0, 0);

    // Four taken BNEs at 0x40 (idx 16): 01->10->11->11->11
    bf.pred_pc = 32'h40;
    drive(1, 0, 3'b001, 0, 0, 0, 0, 32'h40, 32'h8, 0);
    #1;
    chk("bne.sameCycleOld", 32'(bf.pred_taken), 32'd0);
    step();
    chk_out("bne1", 1, 1, 32'h48, 32'h48, 1, 0, 0);
    chk_pred("bne1.pred", 32'h40, 1'b1);
    step();
    chk_pred("bne2.pred", 32'h40, 1'b1);
    step();
    chk_pred("bne3.pred", 32'h40, 1'b1);
    step();
    chk_pred("bne4.pred", 32'h40, 1'b1);

    // Not-taken BEQ: 11->10, pred stays 1 (saturated, not wrapped)
    drive(1, 0, 3'b000, 0, 0, 0, 0, 32'h40, 32'h8, 1);
    step();
    chk_out("beqNT", 1, 0, 32'h48, 32'h44, 1, 0, 0);
    chk_pred("beqNT.pred", 32'h40, 1'b1);

    // Illegal funct3 010: no BHT change (counter stays 10)
    drive(1, 0, 3'b010, 1, 0, 0, 0, 32'h40, 32'h8, 1);
    step();
    chk_out("illegal", 1, 0, 32'h48, 32'h44, 0, 1, 0);
    chk_pred("illegal.pred", 32'h40, 1'b1);

    // Kill: no capture, no BHT change
    drive(1, 1, 3'b000, 0, 0, 0, 0, 32'h40, 32'h8, 0);
    step();
    chk("kill.valid", 32'(bf.out_valid), 32'd0);
    chk_pred("kill.pred", 32'h40, 1'b1);

    // Not-taken: 10->01
    drive(1, 0, 3'b000, 0, 0, 0, 0, 32'h40, 32'h8, 0);
    step();
    chk_pred("dec.pred", 32'h40, 1'b0);

    // pc+4 wrap
    drive(1, 0, 3'b000, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h10, 0);
    step();
    chk_out("wrap", 1, 0, 32'h0000_000C, 32'h0, 0, 0, 0);

    // Taken misaligned: mispredict suppressed; idx 0 10->11
    drive(1, 0, 3'b000, 1, 0, 0, 0, 32'h500, 32'h2, 0);
    step();
    chk_out("misalign", 1, 1, 32'h502, 32'h502, 0, 0, 1);
    chk_pred("misalign.bht0", 32'h0, 1'b1);

    // Idle cycle: outputs hold, valid drops
    drive(0, 0, 3'b000, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    step();
    chk("idle.valid", 32'(bf.out_valid), 32'd0);
    chk("idle.holdTarget", bf.out_target, 32'h502);

    // rst overrides an accept in the same cycle
    drive(1, 0, 3'b000, 1, 0, 0, 0, 32'h40, 32'h8, 0);
    rst = 1'b1;
    step();
    chk("midrst.valid", 32'(bf.out_valid), 32'd0);
    chk("midrst.target", bf.out_target, 32'h0);
    chk_pred("midrst.bht0", 32'h0, 1'b0);
    chk_pred("midrst.bht16", 32'h40, 1'b0);
    rst = 1'b0;

    // Counter restarted at 01 (one taken makes it predict taken)
    drive(1, 0, 3'b000, 1, 0, 0, 0, 32'h0, 32'h4, 0);
    step();
    chk_out("postrst", 1, 1, 32'h4, 32'h4, 1, 0, 0);
    chk_pred("postrst.bht0", 32'h0, 1'b1);

    drive(0, 0, 3'b000, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
